// File: rtl/frame_width_fifo.sv
// frame_width_fifo: single-clock width-converting FIFO for the DDR write path.
// Packs RATIO narrow input words into one OUT_W beat, reports the water level
// and burst readiness, and flushes all stored and partial data on each rising
// edge of the frame vsync.
// Build option: define FRAME_FIFO_FWFT_EN for first-word fall-through reads;
// leave it undefined for the standard 1-cycle read latency.
module frame_width_fifo #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned RATIO     = 8,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned FLUSH_CYC = 15
) (
  input  logic                          ddr_clk,
  input  logic                          rst,
  input  logic                          vs_in,
  input  logic                          wr_en,
  input  logic [IN_W-1:0]               wr_data,
  output logic                          wr_full,
  input  logic                          rd_en,
  output logic [IN_W*RATIO-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          rd_empty,
  output logic [$clog2(DEPTH):0]        water_level,
  output logic                          burst_rdy,
  output logic                          flushing,
  output logic [15:0]                   ovf_cnt
);

  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LVL_W  = AW + 1;
  localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned FC_W   = $clog2(FLUSH_CYC + 1);

  logic                 vs_d1, vs_d2;
  logic [FC_W-1:0]      flush_cnt;
  logic [LANE_W-1:0]    lane;
  logic [OUT_W-1:0]     pack;
  logic [OUT_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [OUT_W-1:0]     word_c;
  logic                 wr_acc_c, rd_acc_c, push_c;

  // Status derived from registered state only
  assign flushing    = (flush_cnt != '0);
  assign water_level = level;
  assign wr_full     = (level == LVL_W'(DEPTH)) || flushing;
  assign rd_empty    = (level == '0) || flushing;
  assign burst_rdy   = (level >= LVL_W'(BURST_LEN));
  assign wr_acc_c    = wr_en && !wr_full;
  assign rd_acc_c    = rd_en && !rd_empty;
  assign push_c      = wr_acc_c && (lane == LANE_W'(RATIO - 1));

  // Assembled beat: current partial word with the incoming lane merged in
  always_comb begin
    word_c = pack;
    word_c[32'(lane) * IN_W +: IN_W] = wr_data;
  end

  // Beat storage, written when the last lane of a beat is accepted
  always_ff @(posedge ddr_clk) begin
    if (!rst && push_c) begin
      mem[wr_ptr] <= word_c;
    end
  end

  // Vsync edge detect, flush counter, overflow count, packer and pointers
  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      vs_d1     <= 1'b0;
      vs_d2     <= 1'b0;
      flush_cnt <= '0;
      ovf_cnt   <= '0;
      lane      <= '0;
      pack      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      vs_d1 <= vs_in;
      vs_d2 <= vs_d1;
      if (vs_d1 && !vs_d2) begin
        flush_cnt <= FC_W'(FLUSH_CYC);
      end else if (flushing) begin
        flush_cnt <= flush_cnt - FC_W'(1);
      end
      if (wr_en && wr_full && !flushing && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
      if (flushing) begin
        lane   <= '0;
        pack   <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_acc_c) begin
          if (push_c) begin
            lane <= '0;
            pack <= '0;
          end else begin
            lane <= lane + LANE_W'(1);
            pack <= word_c;
          end
        end
        if (push_c) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rd_acc_c) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push_c && !rd_acc_c) begin
          level <= level + LVL_W'(1);
        end else if (!push_c && rd_acc_c) begin
          level <= level - LVL_W'(1);
        end
      end
    end
  end

`ifdef FRAME_FIFO_FWFT_EN
  // Head beat shown directly whenever a complete beat is stored
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = !rd_empty;
`else
  logic [OUT_W-1:0] rd_data_q;
  logic             rd_valid_q;

  // Registered read: data one cycle after an accepted pop, held between pops
  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flushing) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc_c;
      if (rd_acc_c) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_frame_width_fifo.sv
// tb_frame_width_fifo: directed checks of packing, burst flag, overflow,
// flush and retrigger for frame_width_fifo with default parameters.
module tb_frame_width_fifo;

  logic         ddr_clk = 1'b0;
  logic         rst, vs_in, wr_en, rd_en;
  logic [31:0]  wr_data;
  logic         wr_full, rd_valid, rd_empty, burst_rdy, flushing;
  logic [255:0] rd_data;
  logic [9:0]   water_level;
  logic [15:0]  ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  frame_width_fifo dut (
    .ddr_clk     (ddr_clk),
    .rst         (rst),
    .vs_in       (vs_in),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_empty    (rd_empty),
    .water_level (water_level),
    .burst_rdy   (burst_rdy),
    .flushing    (flushing),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 ddr_clk = ~ddr_clk;

  typedef struct {
    logic         wr_en;
    logic [31:0]  wr_data;
    logic         rd_en;
    logic [9:0]   lvl;
    logic         empty;
    logic         valid;
    logic         chk_data;
    logic [255:0] data;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat whose lane k carries the value base+k
  function automatic logic [255:0] mk(input int base);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(base + k);
    return r;
  endfunction

  task automatic write_word(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Pop one beat and compare it, in whichever read mode is built
  task automatic pop_check(input string name, input logic [255:0] exp);
`ifdef FRAME_FIFO_FWFT_EN
    check({name, "_valid"}, 256'(rd_valid), 256'(1));
    check({name, "_data"}, rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
`else
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check({name, "_valid"}, 256'(rd_valid), 256'(1));
    check({name, "_data"}, rd_data, exp);
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; vs_in = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Packing table: eight writes, one pop, an idle cycle, a pop on empty
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 32'(i), 1'b0, (i == 7) ? 10'd1 : 10'd0, (i != 7), 1'b0, 1'b0, '0};
    vecs[8]  = '{1'b0, 32'h0, 1'b1, 10'd0, 1'b1, 1'b1, 1'b1,
                 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1,
                 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, '0};

    repeat (3) step();
    rst = 1'b0;
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_valid", 256'(rd_valid), 256'(0));
    check("rst_rd_empty", 256'(rd_empty), 256'(1));
    check("rst_wr_full", 256'(wr_full), 256'(0));
    check("rst_level", 256'(water_level), 256'(0));
    check("rst_burst", 256'(burst_rdy), 256'(0));
    check("rst_flushing", 256'(flushing), 256'(0));
    check("rst_ovf", 256'(ovf_cnt), 256'(0));

    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; rd_en = vecs[i].rd_en;
      step();
      check($sformatf("vec%0d_level", i), 256'(water_level), 256'(vecs[i].lvl));
      check($sformatf("vec%0d_empty", i), 256'(rd_empty), 256'(vecs[i].empty));
`ifdef FRAME_FIFO_FWFT_EN
      check($sformatf("vec%0d_valid", i), 256'(rd_valid), 256'(!vecs[i].empty));
`else
      check($sformatf("vec%0d_valid", i), 256'(rd_valid), 256'(vecs[i].valid));
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), rd_data, vecs[i].data);
`endif
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Burst flag around 16 stored beats
    for (int k = 0; k < 128; k++) begin
      write_word(32'(k));
      if (k == 126) begin
        check("burst_lvl15", 256'(water_level), 256'(15));
        check("burst_pre", 256'(burst_rdy), 256'(0));
      end
    end
    check("burst_lvl16", 256'(water_level), 256'(16));
    check("burst_rise", 256'(burst_rdy), 256'(1));
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("burst_pop_lvl", 256'(water_level), 256'(15));
    check("burst_pop_flag", 256'(burst_rdy), 256'(0));

    // Overflow: fill completely, then three dropped writes
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4096; i++) write_word(32'(i));
    check("full_level", 256'(water_level), 256'(512));
    check("full_flag", 256'(wr_full), 256'(1));
    for (int i = 0; i < 3; i++) write_word(32'hDEAD_0000 + 32'(i));
    check("ovf_cnt", 256'(ovf_cnt), 256'(3));
    check("ovf_level", 256'(water_level), 256'(512));
    pop_check("ovf_head", mk(0));
    check("ovf_pop_level", 256'(water_level), 256'(511));
    for (int k = 0; k < 7; k++) write_word(32'(1000 + k));
`ifdef FRAME_FIFO_FWFT_EN
    check("pushpop_head", rd_data, mk(8));
`endif
    wr_en = 1'b1; wr_data = 32'd1007; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("pushpop_level", 256'(water_level), 256'(511));
`ifndef FRAME_FIFO_FWFT_EN
    check("pushpop_data", rd_data, mk(8));
`endif
    rd_en = 1'b1;
    repeat (510) step();
    rd_en = 1'b0;
    pop_check("tail_word", mk(1000));
    check("drain_level", 256'(water_level), 256'(0));
    check("drain_empty", 256'(rd_empty), 256'(1));

    // Flush: one full beat plus a partial one, then vsync rises
    for (int i = 0; i < 13; i++) write_word(32'(100 + i));
    check("pre_flush_level", 256'(water_level), 256'(1));
    vs_in = 1'b1;
    step();
    check("flush_delay", 256'(flushing), 256'(0));
    step();
    check("flush_start", 256'(flushing), 256'(1));
    check("flush_empty", 256'(rd_empty), 256'(1));
    check("flush_full", 256'(wr_full), 256'(1));
    n = 1;
    wr_en = 1'b1; wr_data = 32'h0000_0BAD;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!flushing) break;
      n++;
    end
    wr_en = 1'b0;
    check("flush_len", 256'(n), 256'(15));
    check("flush_level", 256'(water_level), 256'(0));
    check("flush_empty_after", 256'(rd_empty), 256'(1));
    check("flush_ovf", 256'(ovf_cnt), 256'(3));
    for (int k = 0; k < 8; k++) write_word(32'(200 + k));
    check("post_flush_level", 256'(water_level), 256'(1));
    pop_check("post_flush_word", mk(200));

    // Retrigger: vsync low then high again five cycles into the flush
    vs_in = 1'b0;
    repeat (3) step();
    vs_in = 1'b1;
    step();
    check("retrig_delay", 256'(flushing), 256'(0));
    wr_en = 1'b1; wr_data = 32'h0000_0BAD;
    step();
    check("retrig_start", 256'(flushing), 256'(1));
    n = 1;
    for (int k = 1; k < 40; k++) begin
      if (k == 5) vs_in = 1'b0;
      if (k == 6) vs_in = 1'b1;
      step();
      if (!flushing) break;
      n++;
    end
    wr_en = 1'b0;
    check("retrig_len", 256'(n), 256'(22));
    check("retrig_ovf", 256'(ovf_cnt), 256'(3));
    check("retrig_level", 256'(water_level), 256'(0));

`ifdef FRAME_FIFO_FWFT_EN
    // Fall-through: a single beat is visible the cycle after its push
    for (int k = 0; k < 8; k++) write_word(32'(300 + k));
    check("fwft_valid", 256'(rd_valid), 256'(1));
    check("fwft_data", rd_data, mk(300));
    check("fwft_empty", 256'(rd_empty), 256'(0));
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("fwft_pop_empty", 256'(rd_empty), 256'(1));
    check("fwft_pop_valid", 256'(rd_valid), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
